game_sequencer: RTL and testbench

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/game_sequencer.sv | 158 +++++++++++++++
 tb/tb_game_sequencer.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// Game frame sequencer: paces the game at the frame tick, runs one physics
// update, one scroll step and a per-pipe collision/score scan each frame,
// and tracks the IDLE / RUN / LOSE game state and the score.
module game_sequencer #(
  parameter int TICK_DIV  = 1666667,
  parameter int NUM_PIPES = 4
) (
  input  logic       board_clk,
  input  logic       Reset,
  input  logic       start,
  input  logic       ack,
  input  logic       flap,
  output logic       phys_req,
  output logic       phys_flap,
  input  logic       phys_done,
  output logic       scroll_en,
  output logic [1:0] pipe_idx,
  output logic       chk_valid,
  input  logic       hit,
  input  logic       passed,
  input  logic       oob,
  output logic [1:0] game_state,
  output logic [7:0] score
);

  localparam int               CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [1:0]       LAST_PIPE = 2'(NUM_PIPES - 1);

  localparam logic [1:0] GS_IDLE = 2'b00;
  localparam logic [1:0] GS_RUN  = 2'b01;
  localparam logic [1:0] GS_LOSE = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TICK,
    S_PHYS,
    S_SCROLL,
    S_CHECK,
    S_LOSE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] tick_cnt;
  logic             flap_latch;
  logic             tick_wrap;
  logic             running;

  assign tick_wrap = (tick_cnt == TICK_LAST);
  assign running   = (state == S_WAIT_TICK) || (state == S_PHYS) ||
                     (state == S_SCROLL)    || (state == S_CHECK);

  // Frame tick counter: free-runs through a game, parked at zero in IDLE so a new game starts a full frame.
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      tick_cnt <= '0;
    end else if (state == S_IDLE) begin
      tick_cnt <= '0;
    end else if (running) begin
      if (tick_wrap) begin
        tick_cnt <= '0;
      end else begin
        tick_cnt <= tick_cnt + CNT_W'(1);
      end
    end
  end

  // Flap latch: remembers a flap until the next physics update; a flap on the PHYS-entry edge carries to the next frame.
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      flap_latch <= 1'b0;
    end else if (state == S_WAIT_TICK && tick_wrap) begin
      flap_latch <= flap;
    end else if (running && flap) begin
      flap_latch <= 1'b1;
    end
  end

  // Main sequencer with registered strobes, pipe index, game state and score.
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      state      <= S_IDLE;
      phys_req   <= 1'b0;
      phys_flap  <= 1'b0;
      scroll_en  <= 1'b0;
      chk_valid  <= 1'b0;
      pipe_idx   <= 2'd0;
      game_state <= GS_IDLE;
      score      <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_WAIT_TICK;
            game_state <= GS_RUN;
            score      <= 8'd0;
          end
        end
        S_WAIT_TICK: begin
          if (tick_wrap) begin
            state     <= S_PHYS;
            phys_req  <= 1'b1;
            phys_flap <= flap_latch;
          end
        end
        S_PHYS: begin
          if (phys_done) begin
            state     <= S_SCROLL;
            phys_req  <= 1'b0;
            phys_flap <= 1'b0;
            scroll_en <= 1'b1;
          end
        end
        S_SCROLL: begin
          state     <= S_CHECK;
          scroll_en <= 1'b0;
          chk_valid <= 1'b1;
          pipe_idx  <= 2'd0;
        end
        S_CHECK: begin
          if (hit || oob) begin
            state      <= S_LOSE;
            chk_valid  <= 1'b0;
            pipe_idx   <= 2'd0;
            game_state <= GS_LOSE;
          end else begin
            if (passed && score != 8'hFF) begin
              score <= score + 8'd1;
            end
            if (pipe_idx == LAST_PIPE) begin
              state     <= S_WAIT_TICK;
              chk_valid <= 1'b0;
              pipe_idx  <= 2'd0;
            end else begin
              pipe_idx <= pipe_idx + 2'd1;
            end
          end
        end
        S_LOSE: begin
          if (ack) begin
            state      <= S_IDLE;
            game_state <= GS_IDLE;
          end
        end
        default: begin
          state      <= S_IDLE;
          phys_req   <= 1'b0;
          phys_flap  <= 1'b0;
          scroll_en  <= 1'b0;
          chk_valid  <= 1'b0;
          pipe_idx   <= 2'd0;
          game_state <= GS_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with a short frame (TICK_DIV=10, NUM_PIPES=4).
module tb_game_sequencer;

  logic       board_clk;
  logic       Reset;
  logic       start;
  logic       ack;
  logic       flap;
  logic       phys_req;
  logic       phys_flap;
  logic       phys_done;
  logic       scroll_en;
  logic [1:0] pipe_idx;
  logic       chk_valid;
  logic       hit;
  logic       passed;
  logic       oob;
  logic [1:0] game_state;
  logic [7:0] score;

  logic       hit_arm;
  logic [1:0] hit_sel;
  logic       pass_arm;
  logic [1:0] pass_sel;

  int checks;
  int fails;

  game_sequencer #(
    .TICK_DIV  (10),
    .NUM_PIPES (4)
  ) dut (
    .board_clk  (board_clk),
    .Reset      (Reset),
    .start      (start),
    .ack        (ack),
    .flap       (flap),
    .phys_req   (phys_req),
    .phys_flap  (phys_flap),
    .phys_done  (phys_done),
    .scroll_en  (scroll_en),
    .pipe_idx   (pipe_idx),
    .chk_valid  (chk_valid),
    .hit        (hit),
    .passed     (passed),
    .oob        (oob),
    .game_state (game_state),
    .score      (score)
  );

  // Collision model: hit / passed assert for a selected pipe slot while it is being checked.
  assign hit    = hit_arm  && chk_valid && (pipe_idx == hit_sel);
  assign passed = pass_arm && chk_valid && (pipe_idx == pass_sel);

  // 100 MHz board clock.
  initial board_clk = 1'b0;
  always #5 board_clk = ~board_clk;

  // Answer one physics request and follow the frame back to WAIT_TICK (or into LOSE).
  task automatic service_frame(output bit timed_out, output logic flap_seen);
    int  n;
    bit  saw_chk;
    timed_out = 1'b0;
    flap_seen = 1'b0;
    saw_chk   = 1'b0;
    n = 0;
    while (phys_req !== 1'b1 && n < 40) begin
      @(negedge board_clk);
      n++;
    end
    if (phys_req !== 1'b1) begin
      timed_out = 1'b1;
    end else begin
      flap_seen = phys_flap;
      phys_done = 1'b1;
      @(negedge board_clk);
      phys_done = 1'b0;
      n = 0;
      while (chk_valid !== 1'b1 && n < 10) begin
        @(negedge board_clk);
        n++;
      end
      if (chk_valid === 1'b1) saw_chk = 1'b1;
      n = 0;
      while (chk_valid === 1'b1 && n < 10) begin
        @(negedge board_clk);
        n++;
      end
      if (!saw_chk || chk_valid === 1'b1) timed_out = 1'b1;
    end
  endtask

  task automatic test_reset();
    bit bad;
    @(negedge board_clk);
    @(negedge board_clk);
    checks++;
    if (game_state !== 2'b00) begin
      fails++;
      $display("[TB] FAIL reset_game_state: got %b expected 00", game_state);
    end
    checks++;
    if ({phys_req, phys_flap, scroll_en, chk_valid} !== 4'b0000) begin
      fails++;
      $display("[TB] FAIL reset_strobes: got %b expected 0000", {phys_req, phys_flap, scroll_en, chk_valid});
    end
    checks++;
    if (score !== 8'd0 || pipe_idx !== 2'd0) begin
      fails++;
      $display("[TB] FAIL reset_score_idx: got score=%0d idx=%0d expected 0/0", score, pipe_idx);
    end
    Reset = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge board_clk);
      if (game_state !== 2'b00 || phys_req !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      fails++;
      $display("[TB] FAIL idle_after_reset: got state=%b req=%b expected 00/0", game_state, phys_req);
    end
  endtask

  task automatic test_frame();
    int k;
    start = 1'b1;
    @(negedge board_clk);
    start = 1'b0;
    k = 1;
    while (phys_req !== 1'b1 && k < 20) begin
      @(negedge board_clk);
      k++;
    end
    checks++;
    if (k != 11) begin
      fails++;
      $display("[TB] FAIL req_latency: got %0d cycles expected 11", k);
    end
    repeat (2) @(negedge board_clk);
    checks++;
    if (phys_req !== 1'b1 || scroll_en !== 1'b0) begin
      fails++;
      $display("[TB] FAIL req_held: got req=%b scroll=%b expected 1/0", phys_req, scroll_en);
    end
    @(negedge board_clk);
    phys_done = 1'b1;
    @(negedge board_clk);
    phys_done = 1'b0;
    checks++;
    if ({scroll_en, phys_req, chk_valid} !== 3'b100) begin
      fails++;
      $display("[TB] FAIL scroll_pulse: got %b expected 100", {scroll_en, phys_req, chk_valid});
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge board_clk);
      checks++;
      if ({chk_valid, scroll_en, pipe_idx} !== {1'b1, 1'b0, 2'(i)}) begin
        fails++;
        $display("[TB] FAIL check_scan_%0d: got valid=%b scroll=%b idx=%0d expected 1/0/%0d",
                 i, chk_valid, scroll_en, pipe_idx, i);
      end
    end
    @(negedge board_clk);
    checks++;
    if (chk_valid !== 1'b0 || game_state !== 2'b01 || score !== 8'd0) begin
      fails++;
      $display("[TB] FAIL frame_end: got valid=%b state=%b score=%0d expected 0/01/0",
               chk_valid, game_state, score);
    end
  endtask

  task automatic test_flap();
    bit   to;
    logic f;
    service_frame(to, f);
    checks++;
    if (to || f !== 1'b0) begin
      fails++;
      $display("[TB] FAIL flap_idle_frame: got timeout=%b flap=%b expected 0/0", to, f);
    end
    flap = 1'b1;
    @(negedge board_clk);
    flap = 1'b0;
    service_frame(to, f);
    checks++;
    if (to || f !== 1'b1) begin
      fails++;
      $display("[TB] FAIL flap_latched: got timeout=%b flap=%b expected 0/1", to, f);
    end
    service_frame(to, f);
    checks++;
    if (to || f !== 1'b0) begin
      fails++;
      $display("[TB] FAIL flap_cleared: got timeout=%b flap=%b expected 0/0", to, f);
    end
  endtask

  task automatic test_hit();
    int n;
    int last;
    bit bad;
    hit_arm  = 1'b1;
    hit_sel  = 2'd2;
    pass_arm = 1'b1;
    pass_sel = 2'd2;
    n = 0;
    while (phys_req !== 1'b1 && n < 40) begin
      @(negedge board_clk);
      n++;
    end
    checks++;
    if (phys_req !== 1'b1) begin
      fails++;
      $display("[TB] FAIL hit_req_timeout: got req=%b expected 1", phys_req);
    end
    phys_done = 1'b1;
    @(negedge board_clk);
    phys_done = 1'b0;
    @(negedge board_clk);
    last = -1;
    n = 0;
    while (chk_valid === 1'b1 && n < 8) begin
      last = int'(pipe_idx);
      @(negedge board_clk);
      n++;
    end
    checks++;
    if (last != 2) begin
      fails++;
      $display("[TB] FAIL hit_last_pipe: got %0d expected 2", last);
    end
    checks++;
    if (game_state !== 2'b10 || score !== 8'd0) begin
      fails++;
      $display("[TB] FAIL hit_lose: got state=%b score=%0d expected 10/0", game_state, score);
    end
    hit_arm  = 1'b0;
    pass_arm = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge board_clk);
      if (chk_valid !== 1'b0 || phys_req !== 1'b0 || scroll_en !== 1'b0 || game_state !== 2'b10) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      fails++;
      $display("[TB] FAIL lose_quiet: got valid=%b req=%b scroll=%b state=%b expected 0/0/0/10",
               chk_valid, phys_req, scroll_en, game_state);
    end
  endtask

  task automatic test_ignored_pulses();
    int k;
    start = 1'b1;
    @(negedge board_clk);
    start = 1'b0;
    checks++;
    if (game_state !== 2'b10) begin
      fails++;
      $display("[TB] FAIL start_in_lose: got %b expected 10", game_state);
    end
    start = 1'b1;
    ack   = 1'b1;
    @(negedge board_clk);
    start = 1'b0;
    ack   = 1'b0;
    @(negedge board_clk);
    checks++;
    if (game_state !== 2'b00) begin
      fails++;
      $display("[TB] FAIL start_ack_in_lose: got %b expected 00", game_state);
    end
    ack = 1'b1;
    @(negedge board_clk);
    ack = 1'b0;
    checks++;
    if (game_state !== 2'b00) begin
      fails++;
      $display("[TB] FAIL ack_in_idle: got %b expected 00", game_state);
    end
    start = 1'b1;
    ack   = 1'b1;
    @(negedge board_clk);
    start = 1'b0;
    ack   = 1'b0;
    checks++;
    if (game_state !== 2'b01 || score !== 8'd0) begin
      fails++;
      $display("[TB] FAIL start_ack_in_idle: got state=%b score=%0d expected 01/0", game_state, score);
    end
    start = 1'b1;
    @(negedge board_clk);
    start = 1'b0;
    ack   = 1'b1;
    @(negedge board_clk);
    ack       = 1'b0;
    phys_done = 1'b1;
    @(negedge board_clk);
    phys_done = 1'b0;
    checks++;
    if (game_state !== 2'b01 || phys_req !== 1'b0 || scroll_en !== 1'b0) begin
      fails++;
      $display("[TB] FAIL run_pulses_ignored: got state=%b req=%b scroll=%b expected 01/0/0",
               game_state, phys_req, scroll_en);
    end
    k = 4;
    while (phys_req !== 1'b1 && k < 30) begin
      @(negedge board_clk);
      k++;
    end
    checks++;
    if (k != 11) begin
      fails++;
      $display("[TB] FAIL run_tick_undisturbed: got req at %0d expected 11", k);
    end
  endtask

  task automatic test_saturate();
    bit   to;
    logic f;
    int   timeouts;
    timeouts = 0;
    pass_arm = 1'b1;
    pass_sel = 2'd1;
    service_frame(to, f);
    if (to) timeouts++;
    checks++;
    if (score !== 8'd1) begin
      fails++;
      $display("[TB] FAIL score_first: got %0d expected 1", score);
    end
    for (int i = 1; i < 254; i++) begin
      service_frame(to, f);
      if (to) timeouts++;
    end
    checks++;
    if (score !== 8'd254) begin
      fails++;
      $display("[TB] FAIL score_254: got %0d expected 254", score);
    end
    for (int i = 254; i < 300; i++) begin
      service_frame(to, f);
      if (to) timeouts++;
    end
    checks++;
    if (score !== 8'd255 || timeouts != 0) begin
      fails++;
      $display("[TB] FAIL score_saturate: got score=%0d timeouts=%0d expected 255/0", score, timeouts);
    end
    oob = 1'b1;
    service_frame(to, f);
    oob = 1'b0;
    pass_arm = 1'b0;
    checks++;
    if (to || game_state !== 2'b10 || score !== 8'd255) begin
      fails++;
      $display("[TB] FAIL oob_lose: got timeout=%b state=%b score=%0d expected 0/10/255", to, game_state, score);
    end
    ack = 1'b1;
    @(negedge board_clk);
    ack = 1'b0;
    checks++;
    if (game_state !== 2'b00 || score !== 8'd255) begin
      fails++;
      $display("[TB] FAIL ack_to_idle: got state=%b score=%0d expected 00/255", game_state, score);
    end
    start = 1'b1;
    @(negedge board_clk);
    start = 1'b0;
    checks++;
    if (game_state !== 2'b01 || score !== 8'd0) begin
      fails++;
      $display("[TB] FAIL restart_clears: got state=%b score=%0d expected 01/0", game_state, score);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    bit bad;
    n = 0;
    while (phys_req !== 1'b1 && n < 40) begin
      @(negedge board_clk);
      n++;
    end
    checks++;
    if (phys_req !== 1'b1) begin
      fails++;
      $display("[TB] FAIL mid_req_timeout: got req=%b expected 1", phys_req);
    end
    #2;
    Reset = 1'b1;
    #1;
    checks++;
    if ({phys_req, phys_flap, scroll_en, chk_valid, game_state, pipe_idx} !== 8'd0) begin
      fails++;
      $display("[TB] FAIL async_reset: got req=%b flap=%b scroll=%b valid=%b state=%b idx=%0d expected all 0",
               phys_req, phys_flap, scroll_en, chk_valid, game_state, pipe_idx);
    end
    @(negedge board_clk);
    Reset     = 1'b0;
    phys_done = 1'b1;
    @(negedge board_clk);
    phys_done = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (game_state !== 2'b00 || scroll_en !== 1'b0 || phys_req !== 1'b0 || chk_valid !== 1'b0) bad = 1'b1;
      @(negedge board_clk);
    end
    checks++;
    if (bad) begin
      fails++;
      $display("[TB] FAIL late_done_ignored: got state=%b scroll=%b req=%b expected 00/0/0",
               game_state, scroll_en, phys_req);
    end
  endtask

  // Sequence the scenarios; a side process watches that the three strobes never overlap.
  initial begin
    checks    = 0;
    fails     = 0;
    Reset     = 1'b1;
    start     = 1'b0;
    ack       = 1'b0;
    flap      = 1'b0;
    phys_done = 1'b0;
    oob       = 1'b0;
    hit_arm   = 1'b0;
    hit_sel   = 2'd0;
    pass_arm  = 1'b0;
    pass_sel  = 2'd0;
    fork
      forever begin
        @(negedge board_clk);
        checks++;
        if ((phys_req === 1'b1 && scroll_en === 1'b1) ||
            (phys_req === 1'b1 && chk_valid === 1'b1) ||
            (scroll_en === 1'b1 && chk_valid === 1'b1)) begin
          fails++;
          $display("[TB] FAIL strobe_exclusive: got req=%b scroll=%b valid=%b expected at most one high",
                   phys_req, scroll_en, chk_valid);
        end
      end
    join_none
    test_reset();
    test_frame();
    test_flap();
    test_hit();
    test_ignored_pulses();
    test_saturate();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
